// File: rtl/axist_rx_arb_pkg.sv
// Shared types and helpers for the packet round-robin RX arbiter.
package axist_rx_arb_pkg;
  typedef enum logic {IDLE = 1'b0, XFER = 1'b1} state_e;

  localparam int PKT_CNT_W = 16;

  function automatic int idx_w(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction
endpackage

// File: rtl/axist_rr_sel.sv
// Rotate-priority selector: first requester at or above ptr_i, wrapping upward.
module axist_rr_sel #(
  parameter int N  = 2,
  parameter int IW = 1
) (
  input  logic [N-1:0]  req_i,
  input  logic [IW-1:0] ptr_i,
  output logic [N-1:0]  gnt_o,
  output logic [IW-1:0] idx_o,
  output logic          any_o
);
  always_comb begin
    gnt_o = '0;
    idx_o = '0;
    any_o = 1'b0;
    for (int i = 0; i < N; i++) begin
      if (!any_o && req_i[(int'(ptr_i) + i) % N]) begin
        any_o = 1'b1;
        gnt_o[(int'(ptr_i) + i) % N] = 1'b1;
        idx_o = IW'((int'(ptr_i) + i) % N);
      end
    end
  end
endmodule

// File: rtl/axist_rx_pkt_rr_arbiter.sv
// Packet-boundary round-robin merge of NUM_PORTS AXI-ST RX streams onto one registered output.
// Optional in-packet stall watchdog with drain of the abandoned packet: define ARB_PKT_TIMEOUT_EN.
module axist_rx_pkt_rr_arbiter
  import axist_rx_arb_pkg::*;
#(
  parameter int NUM_PORTS      = 2,
  parameter int AXI_DW         = 64,
  parameter int NO_OF_BYTES    = AXI_DW / 8,
  parameter int TUSER          = 6,
  parameter int TIMEOUT_CYCLES = 1024,
  localparam int IW            = idx_w(NUM_PORTS)
) (
  input  logic                             i_rx_clk,
  input  logic                             i_rx_reset,
  input  logic [NUM_PORTS-1:0]             i_axist_rx_tvalid,
  input  logic [NUM_PORTS*AXI_DW-1:0]      i_axist_rx_tdata,
  input  logic [NUM_PORTS*NO_OF_BYTES-1:0] i_axist_rx_tkeep,
  input  logic [NUM_PORTS-1:0]             i_axist_rx_tlast,
  input  logic [NUM_PORTS*TUSER-1:0]       i_axist_rx_tuser,
  output logic [NUM_PORTS-1:0]             o_axist_rx_tready,
  input  logic                             i_axi_st_rx_tready,
  output logic                             o_axist_rx_tvalid,
  output logic [AXI_DW-1:0]                o_axist_rx_tdata,
  output logic [NO_OF_BYTES-1:0]           o_axist_rx_tkeep,
  output logic                             o_axist_rx_tlast,
  output logic [TUSER-1:0]                 o_axist_rx_tuser,
  output logic [IW-1:0]                    o_axist_rx_tdest,
  output logic [NUM_PORTS-1:0]             o_grant,
  output logic [NUM_PORTS*PKT_CNT_W-1:0]   o_pkt_count,
  output logic                             o_timeout_err
);
  if (NUM_PORTS < 2 || NUM_PORTS > 8) begin : g_bad_ports
    $error("NUM_PORTS must be 2..8");
  end
  if (TIMEOUT_CYCLES < 1) begin : g_bad_timeout
    $error("TIMEOUT_CYCLES must be >= 1");
  end

  state_e                           state_q, state_d;
  logic [NUM_PORTS-1:0]             grant_q, grant_d;
  logic [IW-1:0]                    gidx_q, gidx_d, ptr_q, ptr_d;
  logic [NUM_PORTS*PKT_CNT_W-1:0]   cnt_q, cnt_d;
  logic                             ovld_q, ovld_d, olast_q, olast_d;
  logic [AXI_DW-1:0]                odata_q, odata_d;
  logic [NO_OF_BYTES-1:0]           okeep_q, okeep_d;
  logic [TUSER-1:0]                 ouser_q, ouser_d;
  logic [IW-1:0]                    odest_q, odest_d;

  logic [NUM_PORTS-1:0] req, win_oh;
  logic [IW-1:0]        win_idx;
  logic                 any_req, out_ready, acc, g_vld, g_last;

  assign out_ready = ~ovld_q | i_axi_st_rx_tready;
  assign g_vld     = i_axist_rx_tvalid[gidx_q];
  assign g_last    = i_axist_rx_tlast[gidx_q];

`ifdef ARB_PKT_TIMEOUT_EN
  localparam int TW = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES + 1) : 1;
  logic [NUM_PORTS-1:0] drain_q, drain_d;
  logic [TW-1:0]        idle_q, idle_d;
  logic                 err_q, err_d;
  // A port still flushing a timed-out packet must not win again until its tlast passes.
  assign req           = i_axist_rx_tvalid & ~drain_q;
  assign o_timeout_err = err_q;
`else
  assign req           = i_axist_rx_tvalid;
  assign o_timeout_err = 1'b0;
`endif

  axist_rr_sel #(.N(NUM_PORTS), .IW(IW)) u_sel (
    .req_i (req),
    .ptr_i (ptr_q),
    .gnt_o (win_oh),
    .idx_o (win_idx),
    .any_o (any_req)
  );

  always_comb begin
    state_d = state_q;
    grant_d = grant_q;
    gidx_d  = gidx_q;
    ptr_d   = ptr_q;
    cnt_d   = cnt_q;
    acc     = 1'b0;
    o_axist_rx_tready = '0;
`ifdef ARB_PKT_TIMEOUT_EN
    drain_d = drain_q;
    idle_d  = idle_q;
    err_d   = 1'b0;
    o_axist_rx_tready = drain_q;
    for (int p = 0; p < NUM_PORTS; p++)
      if (drain_q[p] && i_axist_rx_tvalid[p] && i_axist_rx_tlast[p]) drain_d[p] = 1'b0;
`endif
    case (state_q)
      IDLE: begin
        if (any_req) begin
          state_d = XFER;
          grant_d = win_oh;
          gidx_d  = win_idx;
          ptr_d   = (win_idx == IW'(NUM_PORTS - 1)) ? '0 : win_idx + IW'(1);
        end
      end
      XFER: begin
        o_axist_rx_tready[gidx_q] = o_axist_rx_tready[gidx_q] | out_ready;
        acc = g_vld & out_ready;
        if (acc && g_last) begin
          cnt_d[gidx_q*PKT_CNT_W +: PKT_CNT_W] = cnt_q[gidx_q*PKT_CNT_W +: PKT_CNT_W] + PKT_CNT_W'(1);
          state_d = IDLE;
          grant_d = '0;
        end
`ifdef ARB_PKT_TIMEOUT_EN
        if (g_vld) begin
          idle_d = '0;
        end else if (idle_q == TW'(TIMEOUT_CYCLES - 1)) begin
          idle_d          = '0;
          err_d           = 1'b1;
          state_d         = IDLE;
          grant_d         = '0;
          drain_d[gidx_q] = 1'b1;
        end else begin
          idle_d = idle_q + TW'(1);
        end
`endif
      end
      default: state_d = IDLE;
    endcase

    ovld_d  = ovld_q;
    odata_d = odata_q;
    okeep_d = okeep_q;
    olast_d = olast_q;
    ouser_d = ouser_q;
    odest_d = odest_q;
    if (out_ready) begin
      ovld_d = acc;
      if (acc) begin
        odata_d = i_axist_rx_tdata[gidx_q*AXI_DW +: AXI_DW];
        okeep_d = i_axist_rx_tkeep[gidx_q*NO_OF_BYTES +: NO_OF_BYTES];
        olast_d = g_last;
        ouser_d = i_axist_rx_tuser[gidx_q*TUSER +: TUSER];
        odest_d = gidx_q;
      end
    end
  end

  always_ff @(posedge i_rx_clk) begin
    if (i_rx_reset) begin
      state_q <= IDLE;
      grant_q <= '0;
      gidx_q  <= '0;
      ptr_q   <= '0;
      cnt_q   <= '0;
      ovld_q  <= 1'b0;
      odata_q <= '0;
      okeep_q <= '0;
      olast_q <= 1'b0;
      ouser_q <= '0;
      odest_q <= '0;
    end else begin
      state_q <= state_d;
      grant_q <= grant_d;
      gidx_q  <= gidx_d;
      ptr_q   <= ptr_d;
      cnt_q   <= cnt_d;
      ovld_q  <= ovld_d;
      odata_q <= odata_d;
      okeep_q <= okeep_d;
      olast_q <= olast_d;
      ouser_q <= ouser_d;
      odest_q <= odest_d;
    end
  end

`ifdef ARB_PKT_TIMEOUT_EN
  always_ff @(posedge i_rx_clk) begin
    if (i_rx_reset) begin
      drain_q <= '0;
      idle_q  <= '0;
      err_q   <= 1'b0;
    end else begin
      drain_q <= drain_d;
      idle_q  <= idle_d;
      err_q   <= err_d;
    end
  end
`endif

  assign o_axist_rx_tvalid = ovld_q;
  assign o_axist_rx_tdata  = odata_q;
  assign o_axist_rx_tkeep  = okeep_q;
  assign o_axist_rx_tlast  = olast_q;
  assign o_axist_rx_tuser  = ouser_q;
  assign o_axist_rx_tdest  = odest_q;
  assign o_grant           = grant_q;
  assign o_pkt_count       = cnt_q;
endmodule

// File: tb/tb_axist_rx_pkt_rr_arbiter.sv
// Directed bench: cycle table for the basic handshake, then queue-driven sources for multi-cycle cases.
module tb_axist_rx_pkt_rr_arbiter;
  localparam int NP = 2, DW = 64, NB = 8, TU = 6, TO = 8;

  logic            clk = 1'b0, rst = 1'b1, ds_rdy = 1'b1;
  logic [NP-1:0]   tvalid = '0, tlast = '0, tready;
  logic [NP*DW-1:0] tdata = '0;
  logic [NP*NB-1:0] tkeep = '0;
  logic [NP*TU-1:0] tuser = '0;
  logic            ovld, olast, odest, oerr;
  logic [DW-1:0]   odata;
  logic [NB-1:0]   okeep;
  logic [TU-1:0]   ouser;
  logic [NP-1:0]   ogrant;
  logic [NP*16-1:0] ocnt;

  always #5 clk = ~clk;

  axist_rx_pkt_rr_arbiter #(.NUM_PORTS(NP), .AXI_DW(DW), .NO_OF_BYTES(NB), .TUSER(TU),
                            .TIMEOUT_CYCLES(TO)) dut (
    .i_rx_clk(clk), .i_rx_reset(rst),
    .i_axist_rx_tvalid(tvalid), .i_axist_rx_tdata(tdata), .i_axist_rx_tkeep(tkeep),
    .i_axist_rx_tlast(tlast), .i_axist_rx_tuser(tuser), .o_axist_rx_tready(tready),
    .i_axi_st_rx_tready(ds_rdy), .o_axist_rx_tvalid(ovld), .o_axist_rx_tdata(odata),
    .o_axist_rx_tkeep(okeep), .o_axist_rx_tlast(olast), .o_axist_rx_tuser(ouser),
    .o_axist_rx_tdest(odest), .o_grant(ogrant), .o_pkt_count(ocnt), .o_timeout_err(oerr)
  );

  typedef struct packed {logic [7:0] d; logic [7:0] k; logic l;} beat_t;
  typedef struct {logic [63:0] d; logic [7:0] k; logic l; logic dest; logic [5:0] u; int cyc;} obeat_t;
  typedef struct {
    logic [1:0] v, l; logic [7:0] d0, k0, d1, k1; logic rdy;
    logic [1:0] etr, eg; logic eov; logic [7:0] ed, ek; logic el, edst; logic [15:0] ec0, ec1;
  } vec_t;

  beat_t  q0[$], q1[$];
  obeat_t outq[$];
  logic [1:0] hold = '0;
  int n_chk = 0, n_fail = 0, cyc = 0, n_err = 0, src_acc0 = 0;
  logic [NP-1:0] snap_tready, snap_grant;
  logic snap_ovld, snap_err;
  logic [DW-1:0] snap_data;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  task automatic drive_src();
    tvalid = '0; tlast = '0; tdata = '0; tkeep = '0; tuser = '0;
    if (q0.size() > 0 && !hold[0]) begin
      tvalid[0] = 1'b1; tlast[0] = q0[0].l; tdata[7:0] = q0[0].d;
      tkeep[7:0] = q0[0].k; tuser[5:0] = q0[0].d[5:0];
    end
    if (q1.size() > 0 && !hold[1]) begin
      tvalid[1] = 1'b1; tlast[1] = q1[0].l; tdata[71:64] = q1[0].d;
      tkeep[15:8] = q1[0].k; tuser[11:6] = q1[0].d[5:0];
    end
  endtask

  // One clock: snapshot at negedge, record downstream beats, advance sources after the edge.
  task automatic tick();
    logic [NP-1:0] hs;
    @(negedge clk);
    snap_tready = tready; snap_grant = ogrant; snap_ovld = ovld; snap_data = odata; snap_err = oerr;
    if (oerr) n_err++;
    hs = tvalid & tready;
    if (ovld && ds_rdy) outq.push_back('{odata, okeep, olast, odest, ouser, cyc});
    @(posedge clk); #1;
    if (hs[0]) begin void'(q0.pop_front()); src_acc0++; end
    if (hs[1]) void'(q1.pop_front());
    drive_src();
    cyc++;
  endtask

  task automatic do_reset();
    rst = 1'b1; q0.delete(); q1.delete(); hold = '0; drive_src();
    tick(); tick();
    rst = 1'b0;
  endtask

  task automatic run_out(input int n, input string nm);
    int b = 0;
    while (outq.size() < n && b < 60) begin tick(); b++; end
    chk(nm, outq.size(), n);
  endtask

  task automatic push(input int p, input logic [7:0] d, input logic [7:0] k, input logic l);
    if (p == 0) q0.push_back('{d, k, l}); else q1.push_back('{d, k, l});
  endtask

  vec_t tbl[13];

  initial begin
    tbl[0]  = '{2'b00, 2'b00, 8'h00, 8'h00, 8'h00, 8'h00, 1'b1, 2'b00, 2'b00, 1'b0, 8'h00, 8'h00, 1'b0, 1'b0, 16'd0, 16'd0};
    tbl[1]  = '{2'b11, 2'b00, 8'h10, 8'hFF, 8'h20, 8'h00, 1'b1, 2'b00, 2'b00, 1'b0, 8'h00, 8'h00, 1'b0, 1'b0, 16'd0, 16'd0};
    tbl[2]  = '{2'b11, 2'b00, 8'h10, 8'hFF, 8'h20, 8'h00, 1'b1, 2'b01, 2'b01, 1'b0, 8'h00, 8'h00, 1'b0, 1'b0, 16'd0, 16'd0};
    tbl[3]  = '{2'b11, 2'b01, 8'h11, 8'hFF, 8'h20, 8'h00, 1'b1, 2'b01, 2'b01, 1'b1, 8'h10, 8'hFF, 1'b0, 1'b0, 16'd0, 16'd0};
    tbl[4]  = '{2'b10, 2'b00, 8'h00, 8'h00, 8'h20, 8'h00, 1'b1, 2'b00, 2'b00, 1'b1, 8'h11, 8'hFF, 1'b1, 1'b0, 16'd1, 16'd0};
    tbl[5]  = '{2'b10, 2'b00, 8'h00, 8'h00, 8'h20, 8'h00, 1'b0, 2'b10, 2'b10, 1'b0, 8'h00, 8'h00, 1'b0, 1'b0, 16'd1, 16'd0};
    tbl[6]  = '{2'b10, 2'b10, 8'h00, 8'h00, 8'h21, 8'h3F, 1'b0, 2'b00, 2'b10, 1'b1, 8'h20, 8'h00, 1'b0, 1'b1, 16'd1, 16'd0};
    tbl[7]  = '{2'b10, 2'b10, 8'h00, 8'h00, 8'h21, 8'h3F, 1'b0, 2'b00, 2'b10, 1'b1, 8'h20, 8'h00, 1'b0, 1'b1, 16'd1, 16'd0};
    tbl[8]  = '{2'b10, 2'b10, 8'h00, 8'h00, 8'h21, 8'h3F, 1'b1, 2'b10, 2'b10, 1'b1, 8'h20, 8'h00, 1'b0, 1'b1, 16'd1, 16'd0};
    tbl[9]  = '{2'b00, 2'b00, 8'h00, 8'h00, 8'h00, 8'h00, 1'b1, 2'b00, 2'b00, 1'b1, 8'h21, 8'h3F, 1'b1, 1'b1, 16'd1, 16'd1};
    tbl[10] = '{2'b10, 2'b10, 8'h00, 8'h00, 8'h22, 8'h0F, 1'b1, 2'b00, 2'b00, 1'b0, 8'h00, 8'h00, 1'b0, 1'b0, 16'd1, 16'd1};
    tbl[11] = '{2'b10, 2'b10, 8'h00, 8'h00, 8'h22, 8'h0F, 1'b1, 2'b10, 2'b10, 1'b0, 8'h00, 8'h00, 1'b0, 1'b0, 16'd1, 16'd1};
    tbl[12] = '{2'b00, 2'b00, 8'h00, 8'h00, 8'h00, 8'h00, 1'b1, 2'b00, 2'b00, 1'b1, 8'h22, 8'h0F, 1'b1, 1'b1, 16'd1, 16'd2};

    repeat (2) @(posedge clk);
    #1 rst = 1'b0;

    // Cycle table: inputs applied after the edge, all outputs checked mid-cycle.
    for (int i = 0; i < 13; i++) begin
      tvalid = tbl[i].v; tlast = tbl[i].l; ds_rdy = tbl[i].rdy;
      tdata = '0; tkeep = '0; tuser = '0;
      tdata[7:0] = tbl[i].d0; tdata[71:64] = tbl[i].d1;
      tkeep[7:0] = tbl[i].k0; tkeep[15:8] = tbl[i].k1;
      tuser[5:0] = tbl[i].d0[5:0]; tuser[11:6] = tbl[i].d1[5:0];
      @(negedge clk);
      chk($sformatf("row%0d tready", i), tready, tbl[i].etr);
      chk($sformatf("row%0d grant", i), ogrant, tbl[i].eg);
      chk($sformatf("row%0d tvalid", i), ovld, tbl[i].eov);
      chk($sformatf("row%0d cnt0", i), ocnt[15:0], tbl[i].ec0);
      chk($sformatf("row%0d cnt1", i), ocnt[31:16], tbl[i].ec1);
      if (tbl[i].eov) begin
        chk($sformatf("row%0d tdata", i), odata, {56'h0, tbl[i].ed});
        chk($sformatf("row%0d tkeep", i), okeep, tbl[i].ek);
        chk($sformatf("row%0d tlast", i), olast, tbl[i].el);
        chk($sformatf("row%0d tdest", i), odest, tbl[i].edst);
        chk($sformatf("row%0d tuser", i), ouser, tbl[i].ed[5:0]);
      end
      @(posedge clk); #1;
    end
    ds_rdy = 1'b1;

    // Contention: two 3-beat packets per port, both always requesting.
    do_reset();
    for (int p = 0; p < 2; p++)
      for (int b = 0; b < 6; b++) begin
        logic [7:0] d;
        d = (p == 0 ? 8'h30 : 8'h40) + 8'(b);
        push(p, d, d ^ 8'h5A, (b % 3) == 2);
      end
    outq.delete(); drive_src();
    run_out(12, "contention beat count");
    for (int i = 0; i < outq.size() && i < 12; i++) begin
      int pk, pt, bt;
      logic [7:0] d;
      pk = i / 3; pt = pk % 2; bt = i % 3;
      d = (pt == 0 ? 8'h30 : 8'h40) + 8'((pk / 2) * 3 + bt);
      chk($sformatf("cont%0d data", i), outq[i].d, {56'h0, d});
      chk($sformatf("cont%0d tdest", i), outq[i].dest, pt[0]);
      chk($sformatf("cont%0d tlast", i), outq[i].l, bt == 2);
      chk($sformatf("cont%0d tkeep", i), outq[i].k, d ^ 8'h5A);
      if (i > 0) chk($sformatf("cont%0d gap", i), outq[i].cyc - outq[i-1].cyc, (bt == 0) ? 2 : 1);
    end

    // Backpressure: stall downstream 4 cycles while beat 1 sits in the output stage.
    for (int b = 0; b < 4; b++) push(0, 8'h50 + 8'(b), 8'h01 << b, b == 3);
    outq.delete(); drive_src();
    run_out(1, "bp first beat");
    ds_rdy = 1'b0;
    for (int s = 0; s < 4; s++) begin
      tick();
      chk($sformatf("bp stall%0d tvalid", s), snap_ovld, 1'b1);
      chk($sformatf("bp stall%0d data", s), snap_data, 64'h51);
      chk($sformatf("bp stall%0d tready0", s), snap_tready[0], 1'b0);
    end
    ds_rdy = 1'b1;
    run_out(4, "bp beat count");
    for (int i = 0; i < outq.size() && i < 4; i++) begin
      chk($sformatf("bp%0d data", i), outq[i].d, 64'h50 + 64'(i));
      chk($sformatf("bp%0d tkeep", i), outq[i].k, 8'h01 << i);
      chk($sformatf("bp%0d tlast", i), outq[i].l, i == 3);
    end

    // Reset after 2 beats of a 5-beat packet; pointer must return to port 0.
    for (int b = 0; b < 5; b++) push(0, 8'h60 + 8'(b), 8'hFF, b == 4);
    src_acc0 = 0; drive_src();
    for (int b = 0; b < 30 && src_acc0 < 2; b++) tick();
    chk("rst two beats taken", src_acc0, 2);
    rst = 1'b1; q0.delete(); drive_src();
    tick();
    rst = 1'b0; outq.delete();
    tick();
    chk("rst tvalid", snap_ovld, 1'b0);
    chk("rst grant", snap_grant, 2'b00);
    chk("rst counts", ocnt, 32'h0);
    repeat (3) tick();
    chk("rst no tail beat", outq.size(), 0);
    push(0, 8'h70, 8'hFF, 1'b1); push(1, 8'h80, 8'hFF, 1'b1); drive_src();
    run_out(2, "post-rst beats");
    if (outq.size() >= 2) begin
      chk("post-rst first port", outq[0].dest, 1'b0);
      chk("post-rst first data", outq[0].d, 64'h70);
      chk("post-rst second port", outq[1].dest, 1'b1);
    end

    // Single-beat packets on port 1 with partial keep.
    outq.delete();
    for (int b = 0; b < 4; b++) push(1, 8'h90 + 8'(b), 8'h0F, 1'b1);
    drive_src();
    run_out(4, "single beat count");
    for (int i = 0; i < outq.size() && i < 4; i++) begin
      chk($sformatf("sb%0d tkeep", i), outq[i].k, 8'h0F);
      chk($sformatf("sb%0d tlast", i), outq[i].l, 1'b1);
      chk($sformatf("sb%0d tdest", i), outq[i].dest, 1'b1);
    end
    chk("sb cnt1", ocnt[31:16], 16'd5);
    chk("sb cnt0", ocnt[15:0], 16'd1);

    // Counter wrap: preload near the top, then two packets cross 0xFFFF.
    force dut.cnt_q = {16'd5, 16'hFFFE};
    #1 release dut.cnt_q;
    chk("wrap preload", ocnt[15:0], 16'hFFFE);
    outq.delete();
    push(0, 8'hA0, 8'hFF, 1'b1); push(0, 8'hA1, 8'hFF, 1'b1); drive_src();
    run_out(2, "wrap beats");
    chk("wrap cnt0", ocnt[15:0], 16'h0000);
    chk("wrap cnt1", ocnt[31:16], 16'd5);

`ifdef ARB_PKT_TIMEOUT_EN
    // Port 0 stalls mid-packet with port 1 waiting; its remainder must be swallowed.
    do_reset();
    n_err = 0; src_acc0 = 0; outq.delete();
    push(0, 8'hB0, 8'hFF, 1'b0); push(0, 8'hB1, 8'hFF, 1'b0); push(0, 8'hB2, 8'hFF, 1'b1);
    push(1, 8'hC0, 8'h33, 1'b1);
    drive_src();
    for (int b = 0; b < 20 && src_acc0 < 1; b++) tick();
    hold[0] = 1'b1; drive_src();
    begin
      int first = -1;
      for (int k = 1; k <= 20; k++) begin
        tick();
        if (snap_err && first < 0) first = k;
      end
      chk("to pulse cycle", first, 9);
      chk("to pulse count", n_err, 1);
    end
    hold[0] = 1'b0; drive_src();
    for (int b = 0; b < 20 && q0.size() > 0; b++) tick();
    chk("to drained", q0.size(), 0);
    repeat (3) tick();
    chk("to out count", outq.size(), 2);
    if (outq.size() >= 2) begin
      chk("to next port", outq[1].dest, 1'b1);
      chk("to next data", outq[1].d, 64'hC0);
    end
    chk("to cnt0", ocnt[15:0], 16'd0);
    chk("to cnt1", ocnt[31:16], 16'd1);
    push(0, 8'hD0, 8'hFF, 1'b1); drive_src();
    run_out(3, "to port0 rearb");
    chk("to cnt0 after", ocnt[15:0], 16'd1);
`else
    chk("no timeout pulse", n_err, 0);
`endif

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule

// File: doc/axist_rx_pkt_rr_arbiter.md
Name: axist_rx_pkt_rr_arbiter

Overview:
Packet-boundary round-robin arbiter that shares one downstream AXI-ST RX user channel between NUM_PORTS per-port MAC RX streams. Each input is the output of a per-port AVST-to-AXI-ST RX bridge in SOP-aligned mode. A grant is held from first beat to tlast, so packets are never interleaved. The output is registered with a valid/ready handshake, and per-port packet counters are provided for status.

Parameters:
NUM_PORTS, 2, number of requesting RX streams (2..8)
AXI_DW, 64, data width per stream
NO_OF_BYTES, AXI_DW/8, tkeep width
TUSER, 6, tuser width per stream
TIMEOUT_CYCLES, 1024, idle-beat limit inside a packet (used only with the optional feature)

Ports:
i_rx_clk  in  1  single clock
i_rx_reset  in  1  synchronous, active-high reset
i_axist_rx_tvalid  in  NUM_PORTS  per-port valid
i_axist_rx_tdata  in  NUM_PORTS*AXI_DW  per-port data, port p at [p*AXI_DW +: AXI_DW]
i_axist_rx_tkeep  in  NUM_PORTS*NO_OF_BYTES  per-port byte enables
i_axist_rx_tlast  in  NUM_PORTS  per-port end of packet
i_axist_rx_tuser  in  NUM_PORTS*TUSER  per-port sideband
o_axist_rx_tready  out  NUM_PORTS  per-port ready
i_axi_st_rx_tready  in  1  downstream ready
o_axist_rx_tvalid  out  1  merged valid
o_axist_rx_tdata  out  AXI_DW  merged data
o_axist_rx_tkeep  out  NO_OF_BYTES  merged byte enables
o_axist_rx_tlast  out  1  merged end of packet
o_axist_rx_tuser  out  TUSER  merged sideband
o_axist_rx_tdest  out  $clog2(NUM_PORTS) (min 1)  source port of the current beat
o_grant  out  NUM_PORTS  one-hot active grant, 0 when idle
o_pkt_count  out  NUM_PORTS*16  per-port completed-packet counters
o_timeout_err  out  1  one-cycle pulse on watchdog release (0 without the optional feature)

Behaviour:
- Reset (synchronous, i_rx_reset=1 at a clock edge):
  - all outputs go to 0;
  - state goes to IDLE;
  - the round-robin pointer goes to 0;
  - counters are cleared.
  - A reset mid-packet abandons the packet with no tlast emitted.
- Output register: out_ready = ~o_axist_rx_tvalid | i_axi_st_rx_tready.
  - A beat accepted from the granted port (valid & ready) appears on the outputs on the next edge; latency is 1 cycle.
  - While i_axi_st_rx_tready=0 and output is valid, all output fields hold stable.
  - When out_ready=1 and no beat is accepted, o_axist_rx_tvalid goes to 0.
- States:
  - IDLE: o_grant=0 and all o_axist_rx_tready=0. If any tvalid=1, the winner is the first requesting port at or after the pointer, searching upward with wrap. The grant registers and the state moves to XFER. The pointer becomes (winner+1) mod NUM_PORTS.
  - XFER: o_axist_rx_tready[g] = out_ready; all other ports see ready=0.
    - An accepted beat with tlast=1 increments o_pkt_count[g] (wrapping 0xFFFF->0) and returns the state to IDLE.
    - The output tlast leaves the registered stage in the following cycle.
- Throughput: 1 idle arbitration cycle between packets.
  - A single continuously requesting port gets back-to-back packets separated by exactly 1 bubble cycle on its ready.
- Single-beat packets (tlast on the first beat) are legal. IDLE is re-entered after 1 transfer.
- tkeep and tuser pass through unmodified, including all-zero tkeep.
- o_axist_rx_tdest carries the index of the granted port, registered with the data.

Optional Feature:
Macro ARB_PKT_TIMEOUT_EN.
- When defined:
  - In XFER, a counter counts consecutive cycles with granted tvalid=0. It clears on any granted tvalid=1.
  - When the count reaches TIMEOUT_CYCLES: o_timeout_err pulses for 1 cycle, the state moves to IDLE, and the port is marked "draining".
  - A draining port sees tready=1 outside arbitration. Its beats are discarded, not forwarded and not counted, up to and including its tlast. The flag then clears.
  - A draining port is excluded from arbitration.
  - The arbiter does not emit a synthetic tlast for the truncated packet.
- When undefined: no counter or drain logic exists, and o_timeout_err is tied to 0.

Decomposition:
- Package axist_rx_arb_pkg:
  - state enum {IDLE, XFER};
  - localparam PKT_CNT_W=16;
  - a function returning the port-index width, $clog2 with a minimum of 1.
- Sub-module axist_rr_sel: combinational rotate-priority selector.
  - Inputs: request vector and pointer.
  - Outputs: one-hot winner, index, and any_req.
  - Instantiated once.

Test Plan:
- Reset sequencing: assert i_rx_reset mid-XFER after 2 beats of a 5-beat packet -> next cycle o_axist_rx_tvalid=0, o_grant=0, o_pkt_count=0. A new packet then arbitrates from port 0.
- Contention: NUM_PORTS=2, both ports request 3-beat packets continuously -> output order P0,P1,P0,P1, tdest alternating, 1 bubble between packets, no beat interleaving.
- Backpressure: drop i_axi_st_rx_tready for 4 cycles mid-packet -> output beat held stable, granted tready=0 during the stall, beat order and tkeep unchanged.
- Single-beat packets: port 1 only, tlast on every beat with tkeep=0x0F -> each beat forwarded with tkeep=0x0F and tlast=1, o_pkt_count[1] increments once per beat.
- Counter wrap: preload via 65536 single-beat packets on port 0 -> o_pkt_count[0] reads 0.
- ARB_PKT_TIMEOUT_EN, TIMEOUT_CYCLES=8: port 0 stalls 8 cycles mid-packet while port 1 requests -> o_timeout_err pulses once, port 1 is granted next, late port 0 beats through tlast are discarded, and o_pkt_count[0] is unchanged.
